// File: rtl/qu_fetch_ctrl.sv
// Qu instruction-fetch controller: PC sequencing, 1-cycle imem requests, 2-entry fetch queue to decode.
// Optional misaligned-redirect trap is built when QU_FETCH_MISALIGN_TRAP_EN is defined.
module qu_fetch_ctrl #(
    parameter int                  PC_WIDTH     = 12,
    parameter logic [PC_WIDTH-1:0] PC_RESET_VAL = {PC_WIDTH{1'b0}}
) (
    input  logic                clk,
    input  logic                rst,
    output logic                imem_req_o,
    output logic [PC_WIDTH-1:0] imem_addr_o,
    input  logic [31:0]         imem_rdata_i,
    output logic                instr_valid_o,
    input  logic                instr_ready_i,
    output logic [31:0]         instr_o,
    output logic [PC_WIDTH-1:0] pc_o,
    input  logic                redirect_i,
    input  logic [PC_WIDTH-1:0] redirect_pc_i,
    input  logic                halt_i,
    output logic                misalign_o
);

`ifdef QU_FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {RUN = 2'd0, HALT = 2'd1, TRAP = 2'd2} state_t;
`else
    typedef enum logic [0:0] {RUN = 1'b0, HALT = 1'b1} state_t;
`endif

    state_t              state;
    logic [PC_WIDTH-1:0] pc;
    logic                inflight;
    logic [PC_WIDTH-1:0] inflight_pc;
    logic [31:0]         q_instr [2];
    logic [PC_WIDTH-1:0] q_pc    [2];
    logic                rd_ptr;
    logic                wr_ptr;
    logic [1:0]          count;

    logic                pop;
    logic                push;
    logic                issue;
    logic [PC_WIDTH-1:0] req_addr;
    logic [PC_WIDTH-1:0] target;
    logic                trapped;
    logic                bad_redirect;

`ifdef QU_FETCH_MISALIGN_TRAP_EN
    assign trapped      = (state == TRAP);
    assign target       = redirect_pc_i;
    assign bad_redirect = redirect_i && (redirect_pc_i[1:0] != 2'b00) && !trapped;
    assign misalign_o   = trapped;
`else
    assign trapped      = 1'b0;
    assign target       = redirect_pc_i & {{(PC_WIDTH-2){1'b1}}, 2'b00};
    assign bad_redirect = 1'b0;
    assign misalign_o   = 1'b0;
`endif

    // A redirect hides the queue head in the same cycle it flushes it.
    assign instr_valid_o = (count != 2'd0) && !redirect_i;
    assign instr_o       = q_instr[rd_ptr];
    assign pc_o          = q_pc[rd_ptr];
    assign pop           = instr_valid_o && instr_ready_i;
    assign push          = inflight && !redirect_i;
    assign imem_req_o    = issue;
    assign imem_addr_o   = req_addr;

    // Request decision: redirect target first, otherwise only if the queue can absorb the response.
    always_comb begin
        issue    = 1'b0;
        req_addr = pc;
        if (rst || trapped) begin
            issue = 1'b0;
        end else if (redirect_i) begin
            issue    = (state == RUN) && !halt_i && !bad_redirect;
            req_addr = target;
        end else begin
            issue = (state == RUN) && !halt_i &&
                    (({1'b0, count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
        end
    end

    // PC, in-flight tracking, fetch queue and run/halt/trap state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            pc          <= PC_RESET_VAL;
            inflight    <= 1'b0;
            inflight_pc <= {PC_WIDTH{1'b0}};
            q_instr[0]  <= 32'h0000_0000;
            q_instr[1]  <= 32'h0000_0000;
            q_pc[0]     <= {PC_WIDTH{1'b0}};
            q_pc[1]     <= {PC_WIDTH{1'b0}};
            rd_ptr      <= 1'b0;
            wr_ptr      <= 1'b0;
            count       <= 2'd0;
        end else begin
            inflight    <= issue;
            inflight_pc <= req_addr;

            if (issue) begin
                pc <= req_addr + PC_WIDTH'(4);
            end else if (redirect_i && !trapped) begin
                pc <= target;
            end else begin
                pc <= pc;
            end

            if (redirect_i) begin
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
                count  <= 2'd0;
            end else begin
                if (push) begin
                    q_instr[wr_ptr] <= imem_rdata_i;
                    q_pc[wr_ptr]    <= inflight_pc;
                    wr_ptr          <= ~wr_ptr;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                count <= count + {1'b0, push} - {1'b0, pop};
            end

            case (state)
                RUN: begin
                    if (bad_redirect)         state <= state_t'(2'd2);
                    else if (halt_i && !issue) state <= HALT;
                    else                      state <= RUN;
                end
                HALT: begin
                    if (bad_redirect)   state <= state_t'(2'd2);
                    else if (!halt_i)   state <= RUN;
                    else                state <= HALT;
                end
`ifdef QU_FETCH_MISALIGN_TRAP_EN
                TRAP:    state <= TRAP;
`endif
                default: state <= RUN;
            endcase
        end
    end

endmodule
